// File: rtl/enemy_lane_ctrl_if.sv
// Sprite ROM bus shared by the enemy render pipeline: registered address out, combinational colour back.
interface enemy_lane_ctrl_if #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned COLOR_W = 3
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/enemy_lane_ctrl.sv
// Enemy car manager: per-slot PARKED/MOVING movement, passed counting and a
// 2-stage sprite render pipeline sharing one sprite ROM.
module enemy_lane_ctrl #(
    parameter int unsigned N_ENEMY  = 4,
    parameter int unsigned SPR_W    = 80,
    parameter int unsigned SPR_H    = 121,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned Y_LIMIT  = 601,
    parameter int unsigned Y_PARK   = 620,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned TRANSP   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   move_tick,
    input  logic [N_ENEMY-1:0]     spawn,
    input  logic [10*N_ENEMY-1:0]  spawn_x,
    input  logic [10*N_ENEMY-1:0]  spawn_y,
    input  logic [STEP_W-1:0]      speed,
    input  logic                   collision,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    enemy_lane_ctrl_if.master      rom,
    output logic [COLOR_W-1:0]     pix_data,
    output logic                   pix_valid,
    output logic [10*N_ENEMY-1:0]  pos_x,
    output logic [10*N_ENEMY-1:0]  pos_y,
    output logic [N_ENEMY-1:0]     active,
    output logic                   passed_pulse,
    output logic [7:0]             passed_count
);

    localparam int unsigned PCNT_W = 4;

    typedef enum logic {
        SLOT_PARKED = 1'b0,
        SLOT_MOVING = 1'b1
    } slot_state_e;

    slot_state_e        state_q [N_ENEMY];
    slot_state_e        state_d [N_ENEMY];
    logic [9:0]         pos_x_q [N_ENEMY];
    logic [9:0]         pos_x_d [N_ENEMY];
    logic [9:0]         pos_y_q [N_ENEMY];
    logic [9:0]         pos_y_d [N_ENEMY];
    logic               passed_pulse_q, passed_pulse_d;
    logic [7:0]         passed_count_q, passed_count_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               hit_q, hit_d;
    logic [COLOR_W-1:0] pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;

    logic [10:0]        next_y;
    logic [PCNT_W-1:0]  park_cnt;
    logic [8:0]         cnt_sum;
    logic               win;
    logic [9:0]         dx, dy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                state_q[i] <= SLOT_PARKED;
                pos_x_q[i] <= '0;
                pos_y_q[i] <= 10'(Y_PARK);
            end
            passed_pulse_q <= 1'b0;
            passed_count_q <= '0;
            rom_addr_q     <= '0;
            hit_q          <= 1'b0;
            pix_data_q     <= '0;
            pix_valid_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                state_q[i] <= state_d[i];
                pos_x_q[i] <= pos_x_d[i];
                pos_y_q[i] <= pos_y_d[i];
            end
            passed_pulse_q <= passed_pulse_d;
            passed_count_q <= passed_count_d;
            rom_addr_q     <= rom_addr_d;
            hit_q          <= hit_d;
            pix_data_q     <= pix_data_d;
            pix_valid_q    <= pix_valid_d;
        end
    end

    // Slot movement: spawn restarts a slot and wins over move_tick; collision freezes everything.
    always_comb begin
        park_cnt = '0;
        next_y   = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            state_d[i] = state_q[i];
            pos_x_d[i] = pos_x_q[i];
            pos_y_d[i] = pos_y_q[i];
            next_y     = {1'b0, pos_y_q[i]} + 11'(speed);
            if (!collision) begin
                if (spawn[i]) begin
                    pos_x_d[i] = spawn_x[10*i +: 10];
                    pos_y_d[i] = spawn_y[10*i +: 10];
                    state_d[i] = SLOT_MOVING;
                end else if (state_q[i] == SLOT_MOVING && move_tick) begin
                    if (next_y >= 11'(Y_LIMIT)) begin
                        pos_y_d[i] = 10'(Y_PARK);
                        state_d[i] = SLOT_PARKED;
                        park_cnt   = park_cnt + PCNT_W'(1);
                    end else begin
                        pos_y_d[i] = next_y[9:0];
                    end
                end
            end
        end
        cnt_sum        = {1'b0, passed_count_q} + 9'(park_cnt);
        passed_pulse_d = (park_cnt != '0);
        passed_count_d = (cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0];
    end

    // Render: descending scan so the lowest hitting slot is the one left standing.
    always_comb begin
        hit_d      = 1'b0;
        rom_addr_d = rom_addr_q;
        dx         = '0;
        dy         = '0;
        win        = ({1'b0, hcount} < 11'(H_ACTIVE)) && ({1'b0, vcount} < 11'(V_ACTIVE));
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (win && state_q[i] == SLOT_MOVING &&
                {1'b0, hcount} >= {1'b0, pos_x_q[i]} &&
                {1'b0, hcount} <  {1'b0, pos_x_q[i]} + 11'(SPR_W) &&
                {1'b0, vcount} >= {1'b0, pos_y_q[i]} &&
                {1'b0, vcount} <  {1'b0, pos_y_q[i]} + 11'(SPR_H)) begin
                hit_d = 1'b1;
                dx    = hcount - pos_x_q[i];
                dy    = vcount - pos_y_q[i];
            end
        end
        if (hit_d) begin
            rom_addr_d = ADDR_W'(32'(dy) * SPR_W + 32'(dx));
        end
        pix_data_d  = hit_q ? rom.rom_data : '0;
        pix_valid_d = hit_q && (rom.rom_data != COLOR_W'(TRANSP));
    end

    assign rom.rom_addr   = rom_addr_q;
    assign pix_data       = pix_data_q;
    assign pix_valid      = pix_valid_q;
    assign passed_pulse   = passed_pulse_q;
    assign passed_count   = passed_count_q;

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot_out
        assign pos_x[10*g +: 10] = pos_x_q[g];
        assign pos_y[10*g +: 10] = pos_y_q[g];
        assign active[g]         = (state_q[g] == SLOT_MOVING);
    end

endmodule

// File: tb/tb_enemy_lane_ctrl.sv
// Randomized + directed bench for enemy_lane_ctrl against a behavioural scene model.
module tb_enemy_lane_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          move_tick;
    logic [N-1:0]  spawn;
    logic [10*N-1:0] spawn_x, spawn_y;
    logic [3:0]    speed;
    logic          collision;
    logic [9:0]    hcount, vcount;
    logic [2:0]    pix_data;
    logic          pix_valid;
    logic [10*N-1:0] pos_x, pos_y;
    logic [N-1:0]  active;
    logic          passed_pulse;
    logic [7:0]    passed_count;

    logic [2:0]    rom_mem [0:16383];

    enemy_lane_ctrl_if #(.ADDR_W(14), .COLOR_W(3)) rom_if ();
    assign rom_if.rom_data = rom_mem[rom_if.rom_addr];

    enemy_lane_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .move_tick    (move_tick),
        .spawn        (spawn),
        .spawn_x      (spawn_x),
        .spawn_y      (spawn_y),
        .speed        (speed),
        .collision    (collision),
        .hcount       (hcount),
        .vcount       (vcount),
        .rom          (rom_if.master),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .active       (active),
        .passed_pulse (passed_pulse),
        .passed_count (passed_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // scene model state
    int mx [N];
    int my [N];
    bit ma [N];
    int mcnt, maddr, mpix;
    bit mpulse, mhit, mpv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock: predict from pre-edge inputs/model, then compare every output.
    task automatic step();
        int nx [N];
        int ny [N];
        bit na [N];
        int parked, npix, naddr, h, v, yy;
        bit npv, nhit;
        for (int i = 0; i < N; i++) begin
            nx[i] = mx[i]; ny[i] = my[i]; na[i] = ma[i];
        end
        parked = 0;
        npix = mpix; npv = mpv; naddr = maddr; nhit = mhit;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                nx[i] = 0; ny[i] = 620; na[i] = 0;
            end
            npix = 0; npv = 0; naddr = 0; nhit = 0;
        end else begin
            npix = mhit ? int'(rom_mem[maddr]) : 0;
            npv  = mhit && (npix != 0);
            h = int'(hcount); v = int'(vcount);
            nhit = 0;
            if (h < 640 && v < 480) begin
                for (int i = 0; i < N; i++) begin
                    if (!nhit && ma[i] && h >= mx[i] && h < mx[i] + 80 &&
                        v >= my[i] && v < my[i] + 121) begin
                        nhit = 1;
                        naddr = (v - my[i]) * 80 + (h - mx[i]);
                    end
                end
            end
            if (!collision) begin
                for (int i = 0; i < N; i++) begin
                    if (spawn[i]) begin
                        nx[i] = int'(spawn_x[10*i +: 10]);
                        ny[i] = int'(spawn_y[10*i +: 10]);
                        na[i] = 1;
                    end else if (ma[i] && move_tick) begin
                        yy = my[i] + int'(speed);
                        if (yy >= 601) begin
                            ny[i] = 620; na[i] = 0; parked++;
                        end else begin
                            ny[i] = yy;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            mx[i] = nx[i]; my[i] = ny[i]; ma[i] = na[i];
        end
        if (!reset) begin
            mcnt = 0; mpulse = 0;
        end else begin
            mpulse = (parked > 0);
            mcnt = (mcnt + parked > 255) ? 255 : mcnt + parked;
        end
        mpix = npix; mpv = npv; maddr = naddr; mhit = nhit;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("pos_x%0d", i), 32'(pos_x[10*i +: 10]), mx[i]);
            chk($sformatf("pos_y%0d", i), 32'(pos_y[10*i +: 10]), my[i]);
            chk($sformatf("active%0d", i), 32'(active[i]), 32'(ma[i]));
        end
        chk("passed_pulse", 32'(passed_pulse), 32'(mpulse));
        chk("passed_count", 32'(passed_count), mcnt);
        chk("rom_addr", 32'(rom_if.rom_addr), maddr);
        chk("pix_data", 32'(pix_data), mpix);
        chk("pix_valid", 32'(pix_valid), 32'(mpv));
    endtask

    task automatic idle_inputs();
        move_tick = 0; spawn = '0; collision = 0; speed = 4'd0;
        spawn_x = '0; spawn_y = '0; hcount = 10'd700; vcount = 10'd500;
    endtask

    initial begin
        int hold_y;
        int j;
        for (int a = 0; a < 16384; a++) rom_mem[a] = 3'($urandom_range(0, 7));
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 620; ma[i] = 0;
        end
        mcnt = 0; maddr = 0; mpix = 0; mpulse = 0; mhit = 0; mpv = 0;
        idle_inputs();

        // reset
        reset = 0;
        step(); step();
        chk("rst_pos_y0", 32'(pos_y[9:0]), 620);
        chk("rst_pos_y3", 32'(pos_y[39:30]), 620);
        chk("rst_active", 32'(active), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_count", 32'(passed_count), 0);
        reset = 1;

        // spawn and move
        spawn = 4'b0001; spawn_x[9:0] = 10'd100; spawn_y[9:0] = 10'd0;
        step();
        spawn = '0; speed = 4'd5;
        for (int k = 0; k < 3; k++) begin
            move_tick = 1; step();
            move_tick = 0; step();
        end
        chk("move_pos_y0", 32'(pos_y[9:0]), 15);
        chk("move_active0", 32'(active[0]), 1);

        // single exit
        spawn = 4'b0010; spawn_y[19:10] = 10'd598;
        step();
        spawn = '0; speed = 4'd4; move_tick = 1;
        step();
        move_tick = 0;
        chk("exit_pos_y1", 32'(pos_y[19:10]), 620);
        chk("exit_active1", 32'(active[1]), 0);
        chk("exit_pulse", 32'(passed_pulse), 1);
        step();
        chk("exit_pulse_low", 32'(passed_pulse), 0);
        chk("exit_count", 32'(passed_count), 1);

        // two exits on one tick
        spawn = 4'b1100; spawn_y[29:20] = 10'd600; spawn_y[39:30] = 10'd599;
        step();
        spawn = '0; move_tick = 1;
        step();
        move_tick = 0;
        chk("exit2_count", 32'(passed_count), 3);

        // collision freezes movement and spawning
        hold_y = my[0];
        collision = 1; move_tick = 1; spawn = 4'b0100; spawn_y[29:20] = 10'd10;
        step(); step(); step();
        chk("coll_pos_y0", 32'(pos_y[9:0]), 32'(hold_y));
        chk("coll_active2", 32'(active[2]), 0);
        idle_inputs();
        step();

        // render: overlap slot0/slot1, slot0 wins
        reset = 0; step(); reset = 1;
        rom_mem[163] = 3'd5;
        spawn = 4'b0011;
        spawn_x[9:0] = 10'd100; spawn_y[9:0] = 10'd50;
        spawn_x[19:10] = 10'd90; spawn_y[19:10] = 10'd40;
        step();
        spawn = '0; hcount = 10'd103; vcount = 10'd52;
        step();
        chk("rnd_addr", 32'(rom_if.rom_addr), 163);
        step();
        chk("rnd_pix", 32'(pix_data), 5);
        chk("rnd_valid", 32'(pix_valid), 1);
        rom_mem[163] = 3'd0;
        step();
        chk("rnd_transp_valid", 32'(pix_valid), 0);
        idle_inputs();
        step();

        // saturation
        reset = 0; step(); reset = 1;
        for (int r = 0; r < 65; r++) begin
            spawn = 4'b1111; speed = 4'd1;
            for (int i = 0; i < N; i++) spawn_y[10*i +: 10] = 10'd600;
            step();
            spawn = '0; move_tick = 1;
            step();
            move_tick = 0;
        end
        chk("sat_count", 32'(passed_count), 255);
        idle_inputs();

        // randomized run with occasional mid-frame reset
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) != 0);
            move_tick = ($urandom_range(0, 3) == 0);
            collision = ($urandom_range(0, 9) == 0);
            speed     = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                spawn[i] = ($urandom_range(0, 15) == 0);
                spawn_x[10*i +: 10] = 10'($urandom_range(0, 1023));
                spawn_y[10*i +: 10] = ($urandom_range(0, 3) == 0) ?
                                      10'($urandom_range(560, 1023)) : 10'($urandom_range(0, 560));
            end
            if ($urandom_range(0, 1) == 0) begin
                j = $urandom_range(0, N - 1);
                hcount = 10'(mx[j] + $urandom_range(0, 85));
                vcount = 10'(my[j] + $urandom_range(0, 125));
            end else begin
                hcount = 10'($urandom_range(0, 1023));
                vcount = 10'($urandom_range(0, 1023));
            end
            step();
        end

        // reset mid-run
        reset = 0; step();
        chk("midrst_count", 32'(passed_count), 0);
        chk("midrst_active", 32'(active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
